// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_mem_pkg
// Brief   : Shared encodings and helpers for the MEM-stage load/store unit.
// Rev     : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Byte lanes per memory word
    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    // Access FSM: IDLE accepts requests, WRITE commits a merged sub-word store
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // A request is illegal when its size is reserved, it is not naturally
    // aligned, or it claims to be both a load and a store.
    function automatic logic is_illegal(input logic [1:0] size,
                                        input logic [1:0] addr_lo,
                                        input logic       is_ld,
                                        input logic       is_st);
        return (size == SZ_RSVD)
            || ((size == SZ_HALF) && addr_lo[0])
            || ((size == SZ_WORD) && (addr_lo != 2'b00))
            || (is_ld && is_st);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_lsu_if
// Brief     : EX/MEM request bundle, data-memory port and MEM/WB results.
// Rev       : 1.0  initial release
// ============================================================================
interface mem_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Request from EX/MEM
    logic              req_valid;
    logic              req_load;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    // Word-wide data memory port
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_d_in;
    logic              mem_mrd;
    logic              mem_mwr;
    logic [DATA_W-1:0] mem_d_out;
    // Pipeline control and results
    logic              stall;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              misalign;

    // The load/store unit side
    modport slave (
        input  req_valid, req_load, req_store, req_size, req_signed,
               req_addr, req_wdata, mem_d_out,
        output mem_adr, mem_d_in, mem_mrd, mem_mwr, stall,
               rd_data, rd_valid, misalign
    );

    // Pipeline + memory side
    modport master (
        output req_valid, req_load, req_store, req_size, req_signed,
               req_addr, req_wdata, mem_d_out,
        input  mem_adr, mem_d_in, mem_mrd, mem_mwr, stall,
               rd_data, rd_valid, misalign
    );
endinterface
`default_nettype wire

// File: rtl/mem_lsu_lane_unit.sv
`default_nettype none
// ============================================================================
// Module : lsu_lane_unit
// Brief  : Combinational byte-lane logic: load extraction with sign/zero
//          extension, and store merge of a sub-word into a read word.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_lane_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic [1:0]        size_i,
    input  wire logic              signed_i,
    input  wire logic [1:0]        addr_lo_i,
    input  wire logic [DATA_W-1:0] rdata_i,
    input  wire logic [15:0]       wdata_i,
    output logic      [DATA_W-1:0] load_data_o,
    output logic      [DATA_W-1:0] merge_data_o
);

    // Bit offsets of the addressed byte and half-word within the word
    logic [4:0]  w_byte_ofs;
    logic [4:0]  w_half_ofs;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte_ofs = {addr_lo_i, 3'b000};
    assign w_half_ofs = {addr_lo_i[1], 4'b0000};
    assign w_byte     = rdata_i[w_byte_ofs +: LANE_W];
    assign w_half     = rdata_i[w_half_ofs +: 2*LANE_W];

    // Select the addressed lane(s) and extend to the full word
    always_comb begin
        load_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: load_data_o = {{(DATA_W-8){signed_i & w_byte[7]}}, w_byte};
            SZ_HALF: load_data_o = {{(DATA_W-16){signed_i & w_half[15]}}, w_half};
            default: load_data_o = rdata_i;
        endcase
    end

    // Replace the addressed lane(s) of the read word with the store data
    always_comb begin
        merge_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: merge_data_o[w_byte_ofs +: LANE_W]   = wdata_i[7:0];
            SZ_HALF: merge_data_o[w_half_ofs +: 2*LANE_W] = wdata_i;
            default: merge_data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module : mem_lsu
// Brief  : MEM-stage load/store unit. Word accesses go straight to memory;
//          sub-word stores run a read-modify-write over two cycles with a
//          one-cycle stall. Illegal requests are flagged and never issued.
// Rev    : 1.0  initial release
// ============================================================================
module mem_lsu
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    mem_lsu_if.slave   bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] w_aligned;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merge;
    logic [ADDR_W-1:0] w_adr;
    logic [DATA_W-1:0] w_din;
    logic              w_mrd;
    logic              w_mwr;
    logic              w_stall;

    assign w_aligned = {bus.req_addr[ADDR_W-1:2], 2'b00};

    lsu_lane_unit #(
        .DATA_W (DATA_W)
    ) u_lane (
        .size_i       (bus.req_size),
        .signed_i     (bus.req_signed),
        .addr_lo_i    (bus.req_addr[1:0]),
        .rdata_i      (bus.mem_d_out),
        .wdata_i      (bus.req_wdata[15:0]),
        .load_data_o  (w_load),
        .merge_data_o (w_merge)
    );

    // State and result registers; reset aborts any pending write immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            merge_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            merge_q    <= merge_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Request decode, memory port drive and next-state selection
    always_comb begin
        state_d    = state_q;
        merge_d    = merge_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        misalign_d = 1'b0;
        w_mrd      = 1'b0;
        w_mwr      = 1'b0;
        w_stall    = 1'b0;
        w_adr      = '0;
        w_din      = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (is_illegal(bus.req_size, bus.req_addr[1:0],
                                   bus.req_load, bus.req_store)) begin
                        misalign_d = 1'b1;
                    end else if (bus.req_load) begin
                        w_mrd      = 1'b1;
                        w_adr      = w_aligned;
                        rd_data_d  = w_load;
                        rd_valid_d = 1'b1;
                    end else if (bus.req_store) begin
                        w_adr = w_aligned;
                        if (bus.req_size == SZ_WORD) begin
                            w_mwr = 1'b1;
                            w_din = bus.req_wdata;
                        end else begin
                            // Read phase: capture the merged word, hold upstream
                            w_mrd   = 1'b1;
                            w_stall = 1'b1;
                            merge_d = w_merge;
                            state_d = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                // Upstream still holds req_addr, so it supplies the address
                w_mwr   = 1'b1;
                w_din   = merge_q;
                w_adr   = w_aligned;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_adr  = w_adr;
    assign bus.mem_d_in = w_din;
    assign bus.mem_mrd  = w_mrd;
    assign bus.mem_mwr  = w_mwr;
    assign bus.stall    = w_stall;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.misalign = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_lsu
// Brief  : Scoreboard testbench for mem_lsu with a small word memory model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_lsu;
    import mips_mem_pkg::*;

    logic clk;
    logic rst_n;
    logic preload;
    int   cyc;
    int   errors;
    int   checks;

    logic [31:0] mem [0:15];

    logic [31:0] q_data[$];
    int          q_dcyc[$];
    int          q_mcyc[$];

    mem_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_lsu #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: combinational read, write on rising edge
    assign bus.mem_d_out = mem[bus.mem_adr[5:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899AABB;
        end else if (bus.mem_mwr) begin
            mem[bus.mem_adr[5:2]] <= bus.mem_d_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rd_valid) begin
                if (q_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_valid_unexpected: got 1 expected 0");
                end else begin
                    chk("rd_data", bus.rd_data, q_data.pop_front());
                    chk("rd_latency", cyc, q_dcyc.pop_front());
                end
            end
            if (bus.misalign) begin
                if (q_mcyc.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL misalign_unexpected: got 1 expected 0");
                end else begin
                    chk("misalign_latency", cyc, q_mcyc.pop_front());
                end
            end
        end
    end

    task automatic req_set(input logic ld, input logic st, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_load   = ld;
        bus.req_store  = st;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    task automatic do_load(input string nm, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] exp);
        req_set(1'b1, 1'b0, sz, sg, a, 32'h0);
        @(negedge clk);
        q_data.push_back(exp);
        q_dcyc.push_back(cyc + 1);
        chk({nm, "_mrd"}, {31'b0, bus.mem_mrd}, 32'd1);
        chk({nm, "_mwr"}, {31'b0, bus.mem_mwr}, 32'd0);
        chk({nm, "_adr"}, bus.mem_adr, {a[31:2], 2'b00});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_sub_store(input string nm, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] merged);
        req_set(1'b0, 1'b1, sz, 1'b0, a, wd);
        @(negedge clk);
        chk({nm, "_rd_stall"}, {31'b0, bus.stall}, 32'd1);
        chk({nm, "_rd_mrd"}, {31'b0, bus.mem_mrd}, 32'd1);
        chk({nm, "_rd_mwr"}, {31'b0, bus.mem_mwr}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_wr_stall"}, {31'b0, bus.stall}, 32'd0);
        chk({nm, "_wr_mwr"}, {31'b0, bus.mem_mwr}, 32'd1);
        chk({nm, "_wr_mrd"}, {31'b0, bus.mem_mrd}, 32'd0);
        chk({nm, "_wr_data"}, bus.mem_d_in, merged);
        chk({nm, "_wr_adr"}, bus.mem_adr, {a[31:2], 2'b00});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_illegal(input string nm, input logic ld, input logic st,
                              input logic [1:0] sz, input logic [31:0] a);
        req_set(ld, st, sz, 1'b0, a, 32'hFFFF_FFFF);
        @(negedge clk);
        q_mcyc.push_back(cyc + 1);
        chk({nm, "_mrd"}, {31'b0, bus.mem_mrd}, 32'd0);
        chk({nm, "_mwr"}, {31'b0, bus.mem_mwr}, 32'd0);
        chk({nm, "_stall"}, {31'b0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_misalign"}, {31'b0, bus.misalign}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        cyc = 0; errors = 0; checks = 0;
        rst_n = 1'b0; preload = 1'b1;
        bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0;
        bus.req_size = SZ_BYTE; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, bus.stall}, 32'd0);
        chk("rst_mrd", {31'b0, bus.mem_mrd}, 32'd0);
        chk("rst_mwr", {31'b0, bus.mem_mwr}, 32'd0);
        chk("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        chk("rst_misalign", {31'b0, bus.misalign}, 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; preload = 1'b0;

        // Loads from the word 0x8899AABB at 2000
        do_load("lb_2000",  SZ_BYTE, 1'b1, 32'd2000, 32'hFFFF_FFBB);
        do_load("lbu_2000", SZ_BYTE, 1'b0, 32'd2000, 32'h0000_00BB);
        do_load("lh_2002",  SZ_HALF, 1'b1, 32'd2002, 32'hFFFF_8899);
        do_load("lhu_2002", SZ_HALF, 1'b0, 32'd2002, 32'h0000_8899);
        do_load("lbu_2003", SZ_BYTE, 1'b0, 32'd2003, 32'h0000_0088);

        // Sub-word stores
        do_sub_store("sb_2001", SZ_BYTE, 32'd2001, 32'h0000_005A, 32'h8899_5ABB);
        chk("mem_after_sb", mem[4], 32'h8899_5ABB);
        do_sub_store("sh_2002", SZ_HALF, 32'd2002, 32'h0000_1234, 32'h1234_5ABB);
        chk("mem_after_sh", mem[4], 32'h1234_5ABB);

        // Word store then load back
        req_set(1'b0, 1'b1, SZ_WORD, 1'b0, 32'd2004, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_mwr", {31'b0, bus.mem_mwr}, 32'd1);
        chk("sw_stall", {31'b0, bus.stall}, 32'd0);
        chk("sw_data", bus.mem_d_in, 32'hDEAD_BEEF);
        chk("sw_adr", bus.mem_adr, 32'd2004);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        do_load("lw_2004", SZ_WORD, 1'b0, 32'd2004, 32'hDEAD_BEEF);

        // Illegal and misaligned requests
        do_illegal("lh_2001", 1'b1, 1'b0, SZ_HALF, 32'd2001);
        do_illegal("sw_2006", 1'b0, 1'b1, SZ_WORD, 32'd2006);
        do_illegal("size11",  1'b1, 1'b0, SZ_RSVD, 32'd2000);
        do_illegal("ld_st",   1'b1, 1'b1, SZ_WORD, 32'd2000);
        chk("mem4_after_illegal", mem[4], 32'h1234_5ABB);
        chk("mem5_after_illegal", mem[5], 32'hDEAD_BEEF);

        // Store immediately followed by a load of the same word
        do_sub_store("sb_2000", SZ_BYTE, 32'd2000, 32'h0000_0077, 32'h1234_5A77);
        do_load("lbu_after_sb", SZ_BYTE, 1'b0, 32'd2000, 32'h0000_0077);
        // Back-to-back sub-word stores
        do_sub_store("sh_2000", SZ_HALF, 32'd2000, 32'h0000_CAFE, 32'h1234_CAFE);
        do_sub_store("sb_2002", SZ_BYTE, 32'd2002, 32'h0000_0011, 32'h1211_CAFE);
        chk("mem_after_b2b", mem[4], 32'h1211_CAFE);

        // Reset during the WRITE cycle of a byte store
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        req_set(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'd2003, 32'h0000_00FF);
        @(negedge clk);
        chk("rstw_stall", {31'b0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstw_mwr", {31'b0, bus.mem_mwr}, 32'd0);
        chk("rstw_mrd", {31'b0, bus.mem_mrd}, 32'd0);
        chk("rstw_stall0", {31'b0, bus.stall}, 32'd0);
        chk("rstw_rd_data", bus.rd_data, 32'h0);
        chk("rstw_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        chk("rstw_misalign", {31'b0, bus.misalign}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rstw_mem", mem[4], 32'h8899_AABB);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_load("lbu_2003_post", SZ_BYTE, 1'b0, 32'd2003, 32'h0000_0088);

        repeat (3) @(posedge clk);
        #1;
        chk("rd_queue_empty", q_data.size(), 32'd0);
        chk("mis_queue_empty", q_mcyc.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
